// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 core arbiter slice.
package sha256_pkg;

  localparam int HASH_W           = 256;
  localparam int DEFAULT_MSG_SIZE = 120;

  typedef enum logic [1:0] {
    IDLE,
    START,
    BUSY,
    RESP
  } arb_state_t;

  // Index width with a floor of one bit so degenerate sizes still elaborate.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sha256_core_arbiter_if.sv
// Requester/response channel plus the core start/done handshake.
interface sha256_core_arbiter_if
  import sha256_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int MSG_SIZE = DEFAULT_MSG_SIZE
) ();

  localparam int ID_W = idx_width(NUM_REQ);

  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ*MSG_SIZE-1:0] req_message;
  logic [NUM_REQ-1:0]          req_ready;
  logic                        resp_valid;
  logic [ID_W-1:0]             resp_id;
  logic [HASH_W-1:0]           resp_hash;
  logic                        resp_timeout;
  logic                        resp_ready;
  logic                        core_start;
  logic [MSG_SIZE-1:0]         core_message;
  logic [HASH_W-1:0]           core_hashed;
  logic                        core_done;

  // Arbiter side.
  modport slave (
    input  req_valid, req_message, resp_ready, core_hashed, core_done,
    output req_ready, resp_valid, resp_id, resp_hash, resp_timeout,
           core_start, core_message
  );

  // Requester fabric and core side.
  modport master (
    output req_valid, req_message, resp_ready, core_hashed, core_done,
    input  req_ready, resp_valid, resp_id, resp_hash, resp_timeout,
           core_start, core_message
  );

endinterface

// File: rtl/sha256_core_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request after last_grant, wrapping.
module rr_picker
  import sha256_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]            req,
  input  logic [idx_width(NUM_REQ)-1:0] last_grant,
  output logic [NUM_REQ-1:0]            grant,
  output logic [idx_width(NUM_REQ)-1:0] idx,
  output logic                          any
);

  localparam int IDX_W = idx_width(NUM_REQ);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    // Offsets 1..NUM_REQ so last_grant itself is considered last.
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = IDX_W'((32'(last_grant) + off) % NUM_REQ);
      if (!any && req[cand]) begin
        any         = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sha256_core_arbiter.sv
// Round-robin sharing of one SHA-256 core between NUM_REQ requesters,
// with a BUSY watchdog and a valid/ready response channel.
module sha256_core_arbiter
  import sha256_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int MSG_SIZE = DEFAULT_MSG_SIZE,
  parameter int TIMEOUT  = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  sha256_core_arbiter_if.slave bus
);

  localparam int                ID_W       = idx_width(NUM_REQ);
  localparam int                WD_W       = idx_width(TIMEOUT);
  localparam logic [WD_W-1:0]   WD_LAST    = WD_W'(TIMEOUT - 1);
  localparam logic [ID_W-1:0]   GRANT_RST  = ID_W'(NUM_REQ - 1);

  arb_state_t state_q, state_d;

  logic [ID_W-1:0]     last_grant_q;
  logic [NUM_REQ-1:0]  pick_grant;
  logic [ID_W-1:0]     pick_idx;
  logic                pick_any;
  logic [MSG_SIZE-1:0] pick_msg;

  logic [WD_W-1:0]     wd_q;
  logic [NUM_REQ-1:0]  req_ready;
  logic                accept;
  logic                finish_done;
  logic                finish_timeout;
  logic                resp_fire;

  logic                core_start_q;
  logic [MSG_SIZE-1:0] core_message_q;
  logic                resp_valid_q;
  logic [ID_W-1:0]     resp_id_q;
  logic [HASH_W-1:0]   resp_hash_q;
  logic                resp_timeout_q;

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req        (bus.req_valid),
    .last_grant (last_grant_q),
    .grant      (pick_grant),
    .idx        (pick_idx),
    .any        (pick_any)
  );

  always_comb begin
    pick_msg = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_grant[i]) pick_msg = bus.req_message[i*MSG_SIZE +: MSG_SIZE];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (pick_any) state_d = START;
      START: state_d = BUSY;
      BUSY:  if (bus.core_done || (wd_q == WD_LAST)) state_d = RESP;
      RESP:  if (bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // core_done has priority over the watchdog when both hit in one cycle.
  always_comb begin
    req_ready      = (state_q == IDLE) ? pick_grant : '0;
    accept         = (state_q == IDLE) && pick_any;
    finish_done    = (state_q == BUSY) && bus.core_done;
    finish_timeout = (state_q == BUSY) && !bus.core_done && (wd_q == WD_LAST);
    resp_fire      = (state_q == RESP) && resp_valid_q && bus.resp_ready;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      core_start_q   <= 1'b0;
      core_message_q <= '0;
      resp_id_q      <= '0;
    end else begin
      core_start_q <= accept;
      if (accept) begin
        core_message_q <= pick_msg;
        resp_id_q      <= pick_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_q <= '0;
    end else if (state_q == START) begin
      wd_q <= '0;
    end else if ((state_q == BUSY) && (state_d == BUSY)) begin
      wd_q <= wd_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_valid_q   <= 1'b0;
      resp_hash_q    <= '0;
      resp_timeout_q <= 1'b0;
      last_grant_q   <= GRANT_RST;
    end else begin
      if (finish_done) begin
        resp_valid_q   <= 1'b1;
        resp_hash_q    <= bus.core_hashed;
        resp_timeout_q <= 1'b0;
      end else if (finish_timeout) begin
        resp_valid_q   <= 1'b1;
        resp_hash_q    <= '0;
        resp_timeout_q <= 1'b1;
      end else if (resp_fire) begin
        resp_valid_q <= 1'b0;
        last_grant_q <= resp_id_q;
      end
    end
  end

  assign bus.req_ready    = req_ready;
  assign bus.core_start   = core_start_q;
  assign bus.core_message = core_message_q;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_id      = resp_id_q;
  assign bus.resp_hash    = resp_hash_q;
  assign bus.resp_timeout = resp_timeout_q;

endmodule

// File: tb/tb_sha256_core_arbiter.sv
// Directed bench for sha256_core_arbiter with a latency-programmable stub core.
module tb_sha256_core_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int MSG_SIZE = 120;
  localparam int TIMEOUT  = 16;

  logic clk;
  logic reset;

  sha256_core_arbiter_if #(.NUM_REQ(NUM_REQ), .MSG_SIZE(MSG_SIZE)) bus ();

  sha256_core_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .MSG_SIZE (MSG_SIZE),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] valid;
    int         lat;     // 0: core never finishes
    int         exp_id;
    logic       exp_to;
  } vec_t;

  logic [MSG_SIZE-1:0] msgs [NUM_REQ];
  int stub_lat;
  int stub_cnt;
  int passed;
  int total;

  function automatic logic [255:0] fake_hash(input logic [MSG_SIZE-1:0] m);
    return {m, ~m, 16'ha5c3};
  endfunction

  // Stub core: done pulses stub_lat cycles after the start cycle.
  always @(negedge clk) begin
    bus.core_done = 1'b0;
    if (bus.core_start === 1'b1) begin
      stub_cnt        = stub_lat;
      bus.core_hashed = fake_hash(bus.core_message);
    end else if (stub_cnt > 0) begin
      stub_cnt = stub_cnt - 1;
      if (stub_cnt == 0) bus.core_done = 1'b1;
    end
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic run_txn(input string tag, input logic [3:0] valid, input int lat,
                         input int exp_id, input logic exp_to, output int waited);
    int   n;
    int   viol;
    logic seen;
    stub_lat       = lat;
    bus.req_valid  = valid;
    bus.resp_ready = 1'b1;
    seen   = 1'b0;
    waited = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.req_ready != '0) begin seen = 1'b1; waited = i; break; end
    end
    if (!seen) begin
      check($sformatf("%s accept_wait", tag), 256'(0), 256'(1));
      return;
    end
    check($sformatf("%s grant", tag), 256'(bus.req_ready), 256'(4'b0001 << exp_id));
    @(negedge clk);
    check($sformatf("%s core_start", tag), 256'(bus.core_start), 256'(1));
    check($sformatf("%s core_message", tag), 256'(bus.core_message), 256'(msgs[exp_id]));
    viol = 0;
    seen = 1'b0;
    n    = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.core_start !== 1'b0) viol++;
      if (bus.req_ready != '0) viol++;
      if (bus.resp_valid === 1'b1) begin seen = 1'b1; n = i; break; end
    end
    check($sformatf("%s quiet_while_busy", tag), 256'(viol), 256'(0));
    check($sformatf("%s resp_seen", tag), 256'(seen), 256'(1));
    check($sformatf("%s resp_delay", tag), 256'(n), 256'((lat == 0) ? TIMEOUT + 1 : lat + 1));
    check($sformatf("%s resp_id", tag), 256'(bus.resp_id), 256'(exp_id));
    check($sformatf("%s resp_timeout", tag), 256'(bus.resp_timeout), 256'(exp_to));
    check($sformatf("%s resp_hash", tag), bus.resp_hash,
          exp_to ? 256'(0) : fake_hash(msgs[exp_id]));
    @(posedge clk);
    #1;
  endtask

  vec_t vecs [16];

  initial begin
    int   w;
    int   viol;
    logic seen;
    logic [255:0] hold;

    passed = 0;
    total  = 0;
    msgs[0] = 120'h48656c6c6f2c205348412d32353621;
    msgs[1] = 120'h536173737953617371756174636821;
    msgs[2] = 120'h0f1e2d3c4b5a69788796a5b4c3d2e1;
    msgs[3] = 120'hfedcba98765432100123456789abcd;
    bus.req_message = {msgs[3], msgs[2], msgs[1], msgs[0]};

    vecs[0]  = '{4'b1010, 3,  1, 1'b0};
    vecs[1]  = '{4'b1010, 5,  3, 1'b0};
    vecs[2]  = '{4'b1010, 2,  1, 1'b0};
    vecs[3]  = '{4'b1010, 1,  3, 1'b0};
    vecs[4]  = '{4'b1111, 3,  0, 1'b0};
    vecs[5]  = '{4'b1111, 2,  1, 1'b0};
    vecs[6]  = '{4'b1111, 4,  2, 1'b0};
    vecs[7]  = '{4'b1111, 1,  3, 1'b0};
    vecs[8]  = '{4'b1111, 3,  0, 1'b0};
    vecs[9]  = '{4'b1111, 6,  1, 1'b0};
    vecs[10] = '{4'b1111, 2,  2, 1'b0};
    vecs[11] = '{4'b1111, 3,  3, 1'b0};
    vecs[12] = '{4'b0001, 4,  0, 1'b0};
    vecs[13] = '{4'b0100, 0,  2, 1'b1};
    vecs[14] = '{4'b0100, 16, 2, 1'b0};
    vecs[15] = '{4'b0010, 3,  1, 1'b0};

    reset          = 1'b0;
    stub_lat       = 0;
    bus.req_valid  = '0;
    bus.resp_ready = 1'b1;
    #12;
    check("rst core_start", 256'(bus.core_start), 256'(0));
    check("rst resp_valid", 256'(bus.resp_valid), 256'(0));
    check("rst resp_timeout", 256'(bus.resp_timeout), 256'(0));
    check("rst resp_hash", bus.resp_hash, 256'(0));
    check("rst resp_id", 256'(bus.resp_id), 256'(0));
    check("rst core_message", 256'(bus.core_message), 256'(0));
    check("rst req_ready_idle", 256'(bus.req_ready), 256'(0));
    bus.req_valid = 4'b1111;
    #1;
    check("rst first_winner", 256'(bus.req_ready), 256'(4'b0001));
    bus.req_valid = '0;
    @(posedge clk);
    #1;
    reset = 1'b1;

    for (int v = 0; v < 16; v++) begin
      run_txn($sformatf("vec%0d", v), vecs[v].valid, vecs[v].lat,
              vecs[v].exp_id, vecs[v].exp_to, w);
      check($sformatf("vec%0d accept_latency", v), 256'(w), 256'(1));
    end

    // Back-pressure: response held for 20 cycles, then next grant right after.
    stub_lat       = 3;
    bus.req_valid  = 4'b0100;
    bus.resp_ready = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.core_start === 1'b1) bus.req_valid = 4'b1111;
      if (bus.resp_valid === 1'b1) begin seen = 1'b1; break; end
    end
    check("bp resp_seen", 256'(seen), 256'(1));
    hold = bus.resp_hash;
    check("bp hash", hold, fake_hash(msgs[2]));
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.resp_valid !== 1'b1) viol++;
      if (bus.resp_hash !== hold) viol++;
      if (bus.resp_id !== 2'd2) viol++;
      if (bus.req_ready != '0) viol++;
    end
    check("bp stable", 256'(viol), 256'(0));
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    run_txn("bp_next", 4'b1111, 3, 3, 1'b0, w);
    check("bp_next accept_latency", 256'(w), 256'(1));

    // Reset in the middle of BUSY with req 2 in flight.
    stub_lat      = 0;
    bus.req_valid = 4'b0100;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.core_start === 1'b1) begin seen = 1'b1; break; end
    end
    check("mid_rst started", 256'(seen), 256'(1));
    @(posedge clk);
    @(posedge clk);
    #2;
    reset         = 1'b0;
    bus.req_valid = 4'b0101;
    #1;
    check("mid_rst core_start", 256'(bus.core_start), 256'(0));
    check("mid_rst resp_valid", 256'(bus.resp_valid), 256'(0));
    check("mid_rst resp_hash", bus.resp_hash, 256'(0));
    check("mid_rst resp_id", 256'(bus.resp_id), 256'(0));
    check("mid_rst core_message", 256'(bus.core_message), 256'(0));
    check("mid_rst req_ready", 256'(bus.req_ready), 256'(4'b0001));
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    run_txn("post_rst", 4'b0101, 3, 0, 1'b0, w);
    check("post_rst accept_latency", 256'(w), 256'(1));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sha256_core_arbiter.md
# sha256_core_arbiter

Shares a single SHA-256 core (the `top` hashing datapath, `MSG_SIZE`-bit message in, 256-bit digest out, `start`/`done` handshake) between `NUM_REQ` requesters. The block arbitrates round-robin, latches the winner's message and starts the core. It then waits for `done` under a watchdog and returns the digest to the winner over a valid/ready response channel. It sits between the requester fabric and the core; only this block drives the core's `start` and `message`.

## Interface
- `NUM_REQ`, 4: number of requesters (≥2).
- `MSG_SIZE`, 120: message width in bits; must match the core.
- `TIMEOUT`, 1024: maximum number of BUSY cycles to wait for `core_done` before aborting.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req_valid` in NUM_REQ: request pending, one bit per requester.
- `req_message` in NUM_REQ*MSG_SIZE: requester i's message is at bits [i*MSG_SIZE +: MSG_SIZE].
- `req_ready` out NUM_REQ: one-hot accept; transfer occurs when `req_valid[i] & req_ready[i]`.
- `resp_valid` out 1: response available.
- `resp_id` out $clog2(NUM_REQ): index of the requester that owns the response.
- `resp_hash` out 256: digest, or 0 on timeout.
- `resp_timeout` out 1: response is a watchdog abort.
- `resp_ready` in 1: response consumer accepts.
- `core_start` out 1: one-cycle start pulse to the core.
- `core_message` out MSG_SIZE: latched message, held stable from START until exit from BUSY.
- `core_hashed` in 256: core digest.
- `core_done` in 1: core completion.

## Operation
- FSM states and transitions:
  - IDLE: `req_ready` is the combinational one-hot winner among `req_valid`. The search starts at `last_grant+1` and wraps modulo NUM_REQ. On any valid request, latch the message and id and go to START. With no request, stay in IDLE.
  - START: `core_start`=1 for exactly this cycle, watchdog cleared, then go to BUSY.
  - BUSY: watchdog increments each cycle.
    - `core_done`=1: latch `core_hashed`→`resp_hash`, `resp_timeout`=0, go to RESP.
    - Otherwise, when watchdog = TIMEOUT-1: `resp_hash`=0, `resp_timeout`=1, go to RESP.
    - If `core_done` and the timeout hit occur in the same cycle, `core_done` wins.
  - RESP: `resp_valid`=1, and `resp_id`/`resp_hash`/`resp_timeout` hold stable. On `resp_valid & resp_ready`, set `last_grant`=`resp_id` and go to IDLE.
- `req_ready` is 0 outside IDLE. `core_done` outside BUSY is ignored.
- A requester that drops `req_valid` before it is granted loses nothing; no state is kept per requester.
- A timeout does not reset the core. The system owner resets it.
- Watchdog width is $clog2(TIMEOUT) and it never wraps; saturation is reached only via the exit condition.
- Reset values:
  - state IDLE.
  - `last_grant` = NUM_REQ-1, so requester 0 wins first.
  - `core_start`, `resp_valid`, `resp_timeout` = 0.
  - `resp_hash`, `core_message`, `resp_id`, watchdog = 0.

## Timing
- Accept at edge T. `core_start` is high in cycle T+1 and BUSY begins at T+2.
- `core_done` sampled high at edge D → `resp_valid` high from D+1.
- Minimum accept-to-next-accept: 4 cycles plus core latency. After a RESP handshake at edge R, IDLE is in cycle R+1 and the next accept is at R+1 at the earliest.
- Timeout: `resp_valid` rises exactly TIMEOUT+1 cycles after `core_start`.
- Reset asserted in any state: outputs return to reset values immediately (asynchronously). An in-flight response is discarded, and the first grant after release goes to requester 0.
- All outputs except `req_ready` are registered. `req_ready` is combinational from `req_valid`, `last_grant` and state.

## Structure
- Package `sha256_pkg`:
  - `arb_state_t` enum {IDLE, START, BUSY, RESP}.
  - `HASH_W`=256.
  - Default `MSG_SIZE`.
- Sub-module `rr_picker`: combinational round-robin one-hot picker with inputs (request vector, last_grant) and outputs (one-hot grant, encoded index, any). It is parameterised by NUM_REQ.
- Top file contains the FSM, watchdog, message/id latch and response registers.

## Test plan
- Single request: req 0 sends 120'h48656c6c6f2c205348412d32353621 through the real core. Expect `core_start` one cycle after accept, and `resp_hash`=d0e8b8f1…a46271, `resp_id`=0, `resp_timeout`=0.
- Simultaneous requests: reqs 1 and 3 valid together from reset. Expect grant order 1→3; a subsequent 1+3 pair is ordered 1→3 again only if `last_grant`=3. Each `resp_id` must match, and the 3rd response carries "SassySasquatch!" → 6c71746c…7a3b25.
- Fairness: all 4 requesters held valid for 8 transactions. Expect grant sequence 0,1,2,3,0,1,2,3, with no `req_ready` outside IDLE.
- Back-pressure: hold `resp_ready`=0 for 20 cycles. Expect `resp_valid`/`resp_hash` stable, `req_ready`=0 throughout, and the next grant one cycle after the handshake.
- Timeout: stub core never asserts done, with TIMEOUT=16. Expect `resp_valid` 17 cycles after `core_start`, `resp_hash`=0, `resp_timeout`=1. A second case drives `core_done` in the timeout cycle and expects `resp_timeout`=0.
- Reset mid-BUSY: assert `reset`=0 between clock edges. Expect outputs at reset values immediately. After release, the first grant goes to req 0 even if req 2 was in flight.
